// File: rtl/spike_rate_window_if.sv
// Bundle between the bin-count producer/consumer and spike_rate_window.
// Carries the count strobe, thresholds, window results and an FSM debug view.
interface spike_rate_window_if #(
    parameter int IN_W     = 32,
    parameter int CNT_W    = 16,
    parameter int LOG2_WIN = 3,
    parameter int SUM_W    = CNT_W + LOG2_WIN
);
    // cnt_valid is a one-cycle strobe with no ready: the block accepts every
    // strobe unless clear is high in the same cycle. rate_valid is the
    // matching one-cycle result strobe, also without back-pressure.
    logic             clear;
    logic [IN_W-1:0]  cnt_in;
    logic             cnt_valid;
    logic [CNT_W-1:0] thr_hi;
    logic [CNT_W-1:0] thr_lo;
    logic [SUM_W-1:0] rate_sum;
    logic [CNT_W-1:0] rate_avg;
    logic             rate_valid;
    logic             window_full;
    logic             sat_flag;
    logic             over_thresh;
    logic             fsm_state;

    modport master (
        output clear, cnt_in, cnt_valid, thr_hi, thr_lo,
        input  rate_sum, rate_avg, rate_valid, window_full, sat_flag,
               over_thresh, fsm_state
    );

    modport slave (
        input  clear, cnt_in, cnt_valid, thr_hi, thr_lo,
        output rate_sum, rate_avg, rate_valid, window_full, sat_flag,
               over_thresh, fsm_state
    );
endinterface

// File: rtl/spike_rate_window.sv
// Sliding-window sum/average of per-bin spike counts with a rate threshold flag.
// Define SPIKE_RATE_HYST_EN to make over_thresh a thr_hi/thr_lo hysteresis latch.
module spike_rate_window #(
    parameter int IN_W     = 32,
    parameter int CNT_W    = 16,
    parameter int LOG2_WIN = 3,
    parameter int SUM_W    = CNT_W + LOG2_WIN
) (
    input  logic                slow_clk,
    input  logic                reset,
    spike_rate_window_if.slave  bus
);
    localparam int DEPTH = 1 << LOG2_WIN;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [LOG2_WIN-1:0] wp_q, wp_d;
    logic [LOG2_WIN:0]   fill_q, fill_d;
    logic                full_q, full_d;
    logic                sat_q, sat_d;
    logic                valid_q, valid_d;
    logic                over_q, over_d;
    logic [CNT_W-1:0]    buf_q [DEPTH];

    logic                sat_hit;
    logic [CNT_W-1:0]    c;
    logic                wr_en;
    logic [LOG2_WIN:0]   fill_inc;
    logic [CNT_W-1:0]    avg;

    assign sat_hit  = |bus.cnt_in[IN_W-1:CNT_W];
    assign c        = sat_hit ? CNT_MAX : bus.cnt_in[CNT_W-1:0];
    assign fill_inc = fill_q + 1'b1;
    assign avg      = sum_q[SUM_W-1:LOG2_WIN];

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        wp_d    = wp_q;
        fill_d  = fill_q;
        full_d  = full_q;
        sat_d   = sat_q;
        valid_d = 1'b0;
        wr_en   = 1'b0;
        if (bus.clear) begin
            state_d = FILL;
            sum_d   = '0;
            wp_d    = '0;
            fill_d  = '0;
            full_d  = 1'b0;
            sat_d   = 1'b0;
        end else if (bus.cnt_valid) begin
            valid_d = 1'b1;
            wr_en   = 1'b1;
            sat_d   = sat_q | sat_hit;
            wp_d    = wp_q + 1'b1;
            unique case (state_q)
                FILL: begin
                    // Oldest slot is still unwritten, so nothing is subtracted.
                    sum_d  = sum_q + SUM_W'(c);
                    fill_d = fill_inc;
                    if (fill_inc[LOG2_WIN]) begin
                        state_d = RUN;
                        full_d  = 1'b1;
                    end
                end
                RUN: sum_d = sum_q + SUM_W'(c) - SUM_W'(buf_q[wp_q]);
                default: state_d = FILL;
            endcase
        end
    end

    // Threshold decision works on the registered average, hence one edge late.
`ifdef SPIKE_RATE_HYST_EN
    always_comb begin
        over_d = over_q;
        if (full_q && (avg >= bus.thr_hi))
            over_d = 1'b1;
        else if (!full_q || (avg < bus.thr_lo))
            over_d = 1'b0;
    end
`else
    logic unused_thr_lo;
    assign unused_thr_lo = ^bus.thr_lo;
    always_comb begin
        over_d = full_q && (avg >= bus.thr_hi);
    end
`endif

    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            sum_q   <= '0;
            wp_q    <= '0;
            fill_q  <= '0;
            full_q  <= 1'b0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            wp_q    <= wp_d;
            fill_q  <= fill_d;
            full_q  <= full_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            over_q  <= bus.clear ? 1'b0 : over_d;
        end
    end

    // Buffer is never read before written, so it carries no reset.
    always_ff @(posedge slow_clk) begin
        if (wr_en)
            buf_q[wp_q] <= c;
    end

    assign bus.rate_sum    = sum_q;
    assign bus.rate_avg    = avg;
    assign bus.rate_valid  = valid_q;
    assign bus.window_full = full_q;
    assign bus.sat_flag    = sat_q;
    assign bus.over_thresh = over_q;
    assign bus.fsm_state   = state_q;
endmodule

// File: tb/tb_spike_rate_window.sv
// Directed table-driven bench for spike_rate_window with a 4-bin window.
// Expected over_thresh follows the SPIKE_RATE_HYST_EN build choice.
module tb_spike_rate_window;
    localparam int IN_W     = 32;
    localparam int CNT_W    = 16;
    localparam int LOG2_WIN = 2;
    localparam int SUM_W    = CNT_W + LOG2_WIN;
`ifdef SPIKE_RATE_HYST_EN
    localparam logic HYST = 1'b1;
`else
    localparam logic HYST = 1'b0;
`endif

    typedef struct {
        logic             clr;
        logic             vld;
        logic [IN_W-1:0]  cnt;
        logic [SUM_W-1:0] sum;
        logic [CNT_W-1:0] avg;
        logic             rv;
        logic             full;
        logic             sat;
        logic             over;
    } vec_t;

    logic slow_clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t vecs[$];

    spike_rate_window_if #(
        .IN_W(IN_W), .CNT_W(CNT_W), .LOG2_WIN(LOG2_WIN), .SUM_W(SUM_W)
    ) bus ();

    spike_rate_window #(
        .IN_W(IN_W), .CNT_W(CNT_W), .LOG2_WIN(LOG2_WIN), .SUM_W(SUM_W)
    ) dut (
        .slow_clk (slow_clk),
        .reset    (reset),
        .bus      (bus)
    );

    initial slow_clk = 1'b0;
    always #5 slow_clk = ~slow_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic clr, input logic vld, input logic [IN_W-1:0] cnt,
                       input logic [SUM_W-1:0] sum, input logic [CNT_W-1:0] avg,
                       input logic rv, input logic full, input logic sat, input logic over);
        vec_t v;
        v.clr = clr; v.vld = vld; v.cnt = cnt; v.sum = sum; v.avg = avg;
        v.rv = rv; v.full = full; v.sat = sat; v.over = over;
        vecs.push_back(v);
    endtask

    task automatic step(input logic clr, input logic vld, input logic [IN_W-1:0] cnt);
        bus.clear     = clr;
        bus.cnt_valid = vld;
        bus.cnt_in    = cnt;
        @(posedge slow_clk);
        #1;
        bus.clear     = 1'b0;
        bus.cnt_valid = 1'b0;
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, ".rate_sum"},    64'(bus.rate_sum),    64'(v.sum));
        chk({tag, ".rate_avg"},    64'(bus.rate_avg),    64'(v.avg));
        chk({tag, ".rate_valid"},  64'(bus.rate_valid),  64'(v.rv));
        chk({tag, ".window_full"}, 64'(bus.window_full), 64'(v.full));
        chk({tag, ".sat_flag"},    64'(bus.sat_flag),    64'(v.sat));
        chk({tag, ".over_thresh"}, 64'(bus.over_thresh), 64'(v.over));
    endtask

    initial begin
        vec_t z;
        checks = 0;
        errors = 0;
        reset         = 1'b1;
        bus.clear     = 1'b0;
        bus.cnt_valid = 1'b0;
        bus.cnt_in    = '0;
        bus.thr_hi    = 16'd30;
        bus.thr_lo    = 16'd20;

        //   clr  vld  cnt           sum     avg     rv full sat over
        add(0, 1, 32'd10,        18'd10,    16'd2,     1, 0, 0, 0);
        add(0, 1, 32'd20,        18'd30,    16'd7,     1, 0, 0, 0);
        add(0, 1, 32'd30,        18'd60,    16'd15,    1, 0, 0, 0);
        add(0, 1, 32'd40,        18'd100,   16'd25,    1, 1, 0, 0);
        add(0, 0, 32'd0,         18'd100,   16'd25,    0, 1, 0, 0);
        add(0, 1, 32'd50,        18'd140,   16'd35,    1, 1, 0, 0);
        add(0, 1, 32'd0,         18'd120,   16'd30,    1, 1, 0, 1);
        add(0, 0, 32'd0,         18'd120,   16'd30,    0, 1, 0, 1);
        add(0, 1, 32'd10,        18'd100,   16'd25,    1, 1, 0, 1);
        add(0, 0, 32'd0,         18'd100,   16'd25,    0, 1, 0, HYST);
        add(0, 1, 32'd0,         18'd60,    16'd15,    1, 1, 0, HYST);
        add(0, 0, 32'd0,         18'd60,    16'd15,    0, 1, 0, 0);
        add(0, 1, 32'h0001_2345, 18'd65545, 16'd16386, 1, 1, 1, 0);
        add(0, 1, 32'd3,         18'd65548, 16'd16387, 1, 1, 1, 1);
        add(1, 1, 32'd99,        18'd0,     16'd0,     0, 0, 0, 0);
        add(0, 1, 32'd7,         18'd7,     16'd1,     1, 0, 0, 0);
        add(0, 0, 32'd0,         18'd7,     16'd1,     0, 0, 0, 0);
        add(0, 1, 32'h0002_0000, 18'd65542, 16'd16385, 1, 0, 1, 0);
        add(0, 1, 32'd2,         18'd65544, 16'd16386, 1, 0, 1, 0);
        add(0, 1, 32'd3,         18'd65547, 16'd16386, 1, 1, 1, 0);

        #3;
        z = '{clr: 0, vld: 0, cnt: 0, sum: 0, avg: 0, rv: 0, full: 0, sat: 0, over: 0};
        check_outs("reset", z);
        chk("reset.fsm_state", 64'(bus.fsm_state), 64'd0);
        #19;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].clr, vecs[i].vld, vecs[i].cnt);
            check_outs($sformatf("vec%0d", i), vecs[i]);
        end

        // Idle cycle lets the full window push over_thresh high before reset.
        step(1'b0, 1'b0, '0);
        chk("pre_reset.over_thresh", 64'(bus.over_thresh), 64'd1);
        chk("pre_reset.fsm_state",   64'(bus.fsm_state),   64'd1);

        #2;
        reset = 1'b1;
        #1;
        check_outs("async_reset", z);
        chk("async_reset.fsm_state", 64'(bus.fsm_state), 64'd0);
        #3;
        reset = 1'b0;

        step(1'b0, 1'b1, 32'd5);
        z.sum = 18'd5; z.avg = 16'd1; z.rv = 1'b1;
        check_outs("after_reset", z);
        chk("after_reset.fsm_state", 64'(bus.fsm_state), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spike_rate_window.md
Name: spike_rate_window

Overview:
- Downstream consumer of the per-bin spike count produced by the spike counter.
- Once per slow_clk bin (1 ms), takes the latched count and keeps a sliding-window sum and average over the last 2^LOG2_WIN bins.
- Also produces a threshold flag for the downstream rate-coding logic.
- Runs entirely in the slow_clk domain.

Parameters:
- IN_W, 32: width of the incoming bin count.
- CNT_W, 16: saturating width that each bin count is clamped to before accumulation.
- LOG2_WIN, 3: log2 of the window depth; depth = 2^LOG2_WIN bins, legal 1..6.
- SUM_W, CNT_W+LOG2_WIN: width of the running sum. This width makes overflow impossible.

Ports:
- slow_clk, input, 1: bin clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-high.
- clear, input, 1: synchronous window flush.
- cnt_in, input, IN_W: spike count of the last completed bin.
- cnt_valid, input, 1: cnt_in holds a fresh bin this cycle.
- thr_hi, input, CNT_W: upper threshold on rate_avg.
- thr_lo, input, CNT_W: lower threshold on rate_avg; used only with the optional feature.
- rate_sum, output, SUM_W: sum of the bins currently in the window.
- rate_avg, output, CNT_W: rate_sum >> LOG2_WIN.
- rate_valid, output, 1: one-cycle pulse when rate_sum/rate_avg were updated.
- window_full, output, 1: window holds 2^LOG2_WIN bins.
- sat_flag, output, 1: sticky; some cnt_in exceeded 2^CNT_W-1.
- over_thresh, output, 1: rate above threshold.

Behaviour:
- Reset: asynchronous, active-high; clock slow_clk. All outputs go to 0. Write pointer and fill counter go to 0. FSM enters FILL.
- Buffer contents are not reset; they are never read before being written (see FILL).
- Clamp: c = (cnt_in > 2^CNT_W-1) ? 2^CNT_W-1 : cnt_in[CNT_W-1:0]. The clamp case sets sat_flag, which holds until reset or clear.
- Circular buffer: 2^LOG2_WIN x CNT_W registers, single write pointer wp that wraps modulo depth.
- FSM states:
  - FILL: on cnt_valid, buf[wp] <= c, sum <= sum + c, and the oldest entry is NOT subtracted. Fill counter increments. When the fill counter reaches depth, go to RUN and set window_full in the same edge.
  - RUN: on cnt_valid, sum <= sum + c - buf[wp], then buf[wp] <= c. The subtraction uses the pre-write value. The sum never underflows.
- Latency:
  - cnt_valid sampled at edge N gives rate_sum/rate_avg/window_full updated at edge N.
  - rate_valid is high during cycle N..N+1 (registered, one cycle).
  - over_thresh updates at edge N+1, from the registered rate_avg.
- Integration: the upstream counter updates int_cnt_out on posedge slow_clk. The parent asserts cnt_valid one slow_clk after that, from a registered strobe. This block does not synchronise cnt_in.
- cnt_valid low: all state holds and rate_valid = 0.
- rate_avg during FILL is still sum >> LOG2_WIN. It under-reports until window_full; consumers must qualify with window_full.
- clear:
  - Has priority over cnt_valid in the same cycle; that sample is dropped.
  - Sets sum = 0, wp = 0, fill = 0, window_full = 0, sat_flag = 0, over_thresh = 0, FSM = FILL.
  - Pulses rate_valid = 0.
- Reset mid-FILL or mid-RUN: identical to clear, but asynchronous.
- Threshold without the feature: over_thresh = (rate_avg >= thr_hi) && window_full.

Optional Feature:
- Macro: SPIKE_RATE_HYST_EN.
- Defined: over_thresh is a hysteresis latch.
  - Sets when window_full && rate_avg >= thr_hi.
  - Clears when rate_avg < thr_lo, or when window_full drops.
  - Otherwise holds.
  - If thr_lo > thr_hi, the set condition wins.
- Undefined: over_thresh uses the plain comparison defined in Behaviour. thr_lo is unused and is ignored.

Test Plan:
1. Assert reset mid-run with the window full -> all outputs 0 immediately (async), before the next slow_clk edge. After release, the FSM is in FILL.
2. LOG2_WIN=2, cnt_in = 10, 20, 30, 40 on consecutive cnt_valid -> rate_sum 10, 30, 60, 100. window_full rises with the 4th sample; rate_avg = 25; four rate_valid pulses.
3. Continue from scenario 2 with cnt_in = 50, then 0 (wrap) -> rate_sum 140 (avg 35), then 120 (avg 30). window_full stays 1.
4. CNT_W=16, cnt_in = 0x0001_2345 -> buffered value 0xFFFF, sat_flag = 1 and stays 1 after further small inputs, until clear.
5. clear and cnt_valid (cnt_in = 99) in the same cycle -> rate_sum = 0, window_full = 0, rate_valid = 0. The next valid 7 gives rate_sum = 7, with no stale buffer entry subtracted.
6. thr_hi = 30, thr_lo = 20, window full, averages 35 -> 25 -> 15:
   - Without SPIKE_RATE_HYST_EN: over_thresh 1, 0, 0.
   - With SPIKE_RATE_HYST_EN: over_thresh 1, 1, 0.
